// File: rtl/eth_mdc_pkg.sv
// ============================================================================
//  Module      : eth_mdc_pkg
//  Description : Shared types, defaults and the half-period split helper for
//                the MDC burst generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_mdc_pkg;

    localparam int c_DEF_DIV_W   = 8;
    localparam int c_DEF_CNT_W   = 7;
    localparam int c_DEF_MIN_DIV = 2;

    typedef enum logic [1:0] {
        MDC_IDLE = 2'd0,
        MDC_LOW  = 2'd1,
        MDC_HIGH = 2'd2
    } mdc_state_t;

    typedef struct packed {
        logic [31:0] low_m1;
        logic [31:0] high_m1;
    } mdc_split_t;

    // L = ceil(D/2), H = floor(D/2); valid for D >= 2, returned minus one.
    function automatic mdc_split_t mdc_half_split(input logic [31:0] d);
        mdc_split_t s;
        s.low_m1  = (d - 32'd1) >> 1;
        s.high_m1 = (d >> 1) - 32'd1;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/eth_mdc_phase_cnt.sv
// ============================================================================
//  Module      : eth_mdc_phase_cnt
//  Description : Loadable down-counter with zero flag timing one MDC phase.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_mdc_phase_cnt
    import eth_mdc_pkg::*;
#(
    parameter int DIV_W = c_DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/eth_mdc_burst_gen.sv
// ============================================================================
//  Module      : eth_mdc_burst_gen
//  Description : MDC burst generator: N-period bursts, odd/even division,
//                per-edge enables and Done handshake.
//                Optional continuous mode under ETH_MDC_FREERUN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_mdc_burst_gen
    import eth_mdc_pkg::*;
#(
    parameter int DIV_W   = c_DEF_DIV_W,
    parameter int CNT_W   = c_DEF_CNT_W,
    parameter int MIN_DIV = c_DEF_MIN_DIV
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [DIV_W-1:0] Divider,
    input  logic             Start,
    input  logic [CNT_W-1:0] Bits,
`ifdef ETH_MDC_FREERUN_EN
    input  logic             FreeRun,
`endif
    output logic             Mdc,
    output logic             MdcEn,
    output logic             MdcEn_n,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] BitsLeft
);

    mdc_state_t       r_state;
    mdc_state_t       w_state_nxt;
    logic [DIV_W-1:0] r_div_sh;
    logic [DIV_W-1:0] w_div_eff;
    logic [CNT_W-1:0] r_bits_left;
    logic [CNT_W-1:0] w_bits_nxt;
    logic             r_mdc;
    logic             w_mdc_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_free;
    logic             w_free_nxt;
    logic             w_shadow_ld;
    logic             w_cnt_ld;
    logic             w_cnt_dec;
    logic [DIV_W-1:0] w_cnt_val;
    logic             w_cnt_zero;
    logic             w_freerun;
    mdc_split_t       w_split_new;
    mdc_split_t       w_split_sh;
    logic [DIV_W-1:0] w_low_new;
    logic [DIV_W-1:0] w_high_sh;
    logic             w_unused_split;

`ifdef ETH_MDC_FREERUN_EN
    assign w_freerun = FreeRun;
`else
    assign w_freerun = 1'b0;
`endif

    assign w_div_eff = (Divider < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : Divider;

    // A new low phase always uses the divider being latched at that edge; the
    // high phase uses the shadow so a mid-period change cannot distort it.
    assign w_split_new = mdc_half_split(32'(w_div_eff));
    assign w_split_sh  = mdc_half_split(32'(r_div_sh));
    assign w_low_new   = w_split_new.low_m1[DIV_W-1:0];
    assign w_high_sh   = w_split_sh.high_m1[DIV_W-1:0];
    assign w_unused_split = ^{w_split_new.high_m1, w_split_sh.low_m1,
                              w_split_new.low_m1[31:DIV_W],
                              w_split_sh.high_m1[31:DIV_W]};

    eth_mdc_phase_cnt #(
        .DIV_W (DIV_W)
    ) u_phase_cnt (
        .clk        (Clk),
        .rst        (Reset),
        .i_load     (w_cnt_ld),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= MDC_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mdc_nxt   = r_mdc;
        w_done_nxt  = 1'b0;
        w_bits_nxt  = r_bits_left;
        w_free_nxt  = r_free;
        w_shadow_ld = 1'b0;
        w_cnt_ld    = 1'b0;
        w_cnt_val   = '0;
        w_cnt_dec   = 1'b0;
        unique case (r_state)
            MDC_IDLE: begin
                if (w_freerun) begin
                    w_state_nxt = MDC_LOW;
                    w_free_nxt  = 1'b1;
                    w_bits_nxt  = '0;
                    w_shadow_ld = 1'b1;
                    w_cnt_ld    = 1'b1;
                    w_cnt_val   = w_low_new;
                end else if (Start) begin
                    if (Bits != '0) begin
                        w_state_nxt = MDC_LOW;
                        w_free_nxt  = 1'b0;
                        w_bits_nxt  = Bits;
                        w_shadow_ld = 1'b1;
                        w_cnt_ld    = 1'b1;
                        w_cnt_val   = w_low_new;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            MDC_LOW: begin
                if (w_cnt_zero) begin
                    w_state_nxt = MDC_HIGH;
                    w_mdc_nxt   = 1'b1;
                    w_cnt_ld    = 1'b1;
                    w_cnt_val   = w_high_sh;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            MDC_HIGH: begin
                if (w_cnt_zero) begin
                    w_mdc_nxt   = 1'b0;
                    w_shadow_ld = 1'b1;
                    if (r_free) begin
                        if (w_freerun) begin
                            w_state_nxt = MDC_LOW;
                            w_cnt_ld    = 1'b1;
                            w_cnt_val   = w_low_new;
                        end else begin
                            w_state_nxt = MDC_IDLE;
                            w_free_nxt  = 1'b0;
                        end
                    end else begin
                        w_bits_nxt = r_bits_left - CNT_W'(1);
                        if (r_bits_left == CNT_W'(1)) begin
                            w_state_nxt = MDC_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = MDC_LOW;
                            w_cnt_ld    = 1'b1;
                            w_cnt_val   = w_low_new;
                        end
                    end
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: begin
                w_state_nxt = MDC_IDLE;
                w_mdc_nxt   = 1'b0;
                w_free_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mdc       <= 1'b0;
            r_done      <= 1'b0;
            r_bits_left <= '0;
            r_free      <= 1'b0;
            r_div_sh    <= DIV_W'(MIN_DIV);
        end else begin
            r_mdc       <= w_mdc_nxt;
            r_done      <= w_done_nxt;
            r_bits_left <= w_bits_nxt;
            r_free      <= w_free_nxt;
            if (w_shadow_ld) begin
                r_div_sh <= w_div_eff;
            end
        end
    end

    assign Mdc      = r_mdc;
    assign Done     = r_done;
    assign Busy     = (r_state != MDC_IDLE);
    assign BitsLeft = r_bits_left;
    assign MdcEn    = (r_state == MDC_LOW)  && w_cnt_zero;
    assign MdcEn_n  = (r_state == MDC_HIGH) && w_cnt_zero;

endmodule

`default_nettype wire

// File: doc/eth_mdc_burst_gen.md
# eth_mdc_burst_gen

Parametrised successor to the MII management clock divider. It generates MDC as bounded bursts of exactly N clock periods on request, with arbitrary (odd or even) division and glitch-free divider updates at period boundaries. It sits between the MIIM shift/control logic and the MDC pad, and gives the shifters per-edge enables and a completion handshake.

## Interface
- DIV_W, 8: width of Divider and of the internal phase counter.
- CNT_W, 7: width of Bits and BitsLeft; max burst length is 2^CNT_W-1 periods.
- MIN_DIV, 2: smallest effective divider; must be ≥2.

Ports:
- Clk  in  1  host clock.
- Reset  in  1  synchronous, active-high reset.
- Divider  in  DIV_W  MDC period in Clk cycles; values below MIN_DIV clamp to MIN_DIV.
- Start  in  1  one-cycle request; sampled only while Busy=0.
- Bits  in  CNT_W  number of MDC periods in the burst, sampled with Start.
- Mdc  out  1  MDC output, registered, idles low.
- MdcEn  out  1  high for the one Clk cycle before Mdc rises.
- MdcEn_n  out  1  high for the one Clk cycle before Mdc falls.
- Busy  out  1  burst in progress.
- Done  out  1  one-cycle pulse when the burst completes.
- BitsLeft  out  CNT_W  periods remaining, including the current one.

## Operation
- Effective divider: D = max(Divider, MIN_DIV). Low phase L = ceil(D/2) cycles; high phase H = floor(D/2) cycles.
- D is latched into a shadow register on Start and again at every falling edge. A Divider change mid-period never truncates or stretches the current phase.
- FSM states:
  - IDLE: Mdc=0, Busy=0.
  - LOW: counter loaded with L-1.
  - HIGH: counter loaded with H-1.
- IDLE + Start, Bits≠0: go to LOW, latch BitsLeft=Bits and the shadow D.
- IDLE + Start, Bits=0: stay in IDLE, pulse Done on the next cycle, no Mdc edges.
- LOW, counter=0: MdcEn=1; on the next edge Mdc←1 and the FSM goes to HIGH.
- HIGH, counter=0: MdcEn_n=1; on the next edge Mdc←0 and BitsLeft decrements.
  - If BitsLeft was 1: go to IDLE and pulse Done.
  - Otherwise: go to LOW with the reloaded shadow D.
- Otherwise the counter decrements by 1 in the active phase.
- Start while Busy=1 is ignored; it is not queued.
- Start in the same cycle as Done (Busy=0) is accepted.

## Timing
- Reset values: Mdc=0, MdcEn=0, MdcEn_n=0, Busy=0, Done=0, BitsLeft=0, FSM=IDLE, counter=0.
- Start sampled at edge t:
  - Busy=1 from t.
  - Mdc rises at edge t+L and falls at edge t+D.
  - The k-th fall occurs at edge t+k·D.
- The last fall is at edge t+N·D. At that same edge Busy←0 and Done←1. Done clears one edge later.
- MdcEn and MdcEn_n are combinational from the registered state and counter. They are never both high in the same cycle.
- For D=2 (L=H=1), MdcEn and MdcEn_n alternate every cycle.
- Reset asserted mid-burst: all outputs return to reset values at that edge. No Done pulse is produced.

## Configuration
- ETH_MDC_FREERUN_EN defined: adds input port FreeRun (1 bit).
  - FreeRun=1 in IDLE: the FSM enters LOW and runs continuous periods with Busy=1. BitsLeft holds 0. No Done pulses occur. Start is ignored.
  - FreeRun deasserted: the current period completes, and the FSM returns to IDLE at the next falling edge with no Done pulse.
- ETH_MDC_FREERUN_EN undefined: the port is absent and only burst mode exists.

## Structure
- Shared package eth_mdc_pkg holds:
  - the FSM state enum (MDC_IDLE, MDC_LOW, MDC_HIGH);
  - default DIV_W/CNT_W/MIN_DIV localparams;
  - the half-period split function returning L-1 and H-1 for a given D.
- One natural sub-module, eth_mdc_phase_cnt: a loadable down-counter with a zero flag, width DIV_W. The FSM, shadow register and bit counter stay in the top level.

## Test plan
- Divider=8, Start with Bits=3: Mdc high for 4 and low for 4 cycles, exactly 3 rising edges. Done pulses at t+24, and Busy falls at the same edge.
- Divider=5, Bits=2: low for 3 / high for 2 cycles, period 5. MdcEn precedes each rise by one cycle and MdcEn_n precedes each fall by one cycle.
- Divider=0 and Divider=1: behaves as D=2. Mdc toggles every cycle, and MdcEn/MdcEn_n alternate.
- Divider changed from 10 to 4 during a burst's first high phase: the current period stays at 10; subsequent periods are 4; no runt pulse.
- Start with Bits=0 produces only a Done pulse. Start during Busy is ignored, and BitsLeft is unchanged. Start in the Done cycle launches a new burst.
- Reset asserted mid high phase of Bits=5: Mdc=0, Busy=0, Done=0 at the next edge, and no further edges.
